// File: rtl/pwm_rom_player.sv
// pwm_rom_player
// Plays a duty-cycle table stored in an external combinational ROM through
// a PWM output. Each PWM period plays one ROM sample. A run covers addresses
// 0..last_addr, either once or looping.
//
// Ports
//   clk, rst_n            : single clock, asynchronous active-low reset
//   start, stop           : begin a run (accepted in IDLE only) / abort a run
//   loop_en, last_addr,   : run configuration, captured when a run starts
//   prescale                (prescale = clocks per PWM count minus 1)
//   rom_ce, rom_read_en,  : ROM control and address
//   rom_address
//   rom_data              : ROM read data, valid in the same cycle
//   pwm_out               : PWM waveform
//   busy                  : high while loading or running
//   period_tick           : one-cycle pulse at the end of each PWM period
//   done                  : one-cycle pulse after a non-looping run completes
module pwm_rom_player #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDRESS_WIDTH  = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      loop_en,
   input  logic [ADDRESS_WIDTH-1:0]  last_addr,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      rom_ce,
   output logic                      rom_read_en,
   output logic [ADDRESS_WIDTH-1:0]  rom_address,
   input  logic [DATA_WIDTH-1:0]     rom_data,
   output logic                      pwm_out,
   output logic                      busy,
   output logic                      period_tick,
   output logic                      done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Counter runs 0..2^DATA_WIDTH-2 so a full-scale duty of all ones keeps
   // the output high for the entire period.
   localparam logic [DATA_WIDTH-1:0]     CNT_MAX  = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [DATA_WIDTH-1:0]     CNT_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDRESS_WIDTH-1:0]  ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

   state_t                    state_r;
   state_t                    state_nxt_s;
   logic [ADDRESS_WIDTH-1:0]  play_addr_r;
   logic [DATA_WIDTH-1:0]     duty_r;
   logic [DATA_WIDTH-1:0]     cnt_r;
   logic [PRESCALE_WIDTH-1:0] pre_r;
   logic [ADDRESS_WIDTH-1:0]  last_addr_r;
   logic                      loop_en_r;
   logic [PRESCALE_WIDTH-1:0] prescale_r;
   logic                      done_r;

   logic                      run_s;
   logic                      tick_s;
   logic                      period_end_s;
   logic                      at_last_s;
   logic                      finish_s;
   logic [ADDRESS_WIDTH-1:0]  next_addr_s;

   assign run_s        = (state_r == ST_RUN);
   assign tick_s       = run_s && (pre_r == prescale_r);
   assign period_end_s = tick_s && (cnt_r == CNT_MAX);
   assign at_last_s    = (play_addr_r == last_addr_r);
   assign next_addr_s  = at_last_s ? {ADDRESS_WIDTH{1'b0}} : (play_addr_r + ADDR_ONE);
   assign finish_s     = period_end_s && at_last_s && !loop_en_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and output decode; stop outranks both start and period end.
   always_comb begin
      state_nxt_s = state_r;
      rom_ce      = 1'b0;
      rom_read_en = 1'b0;
      rom_address = {ADDRESS_WIDTH{1'b0}};
      busy        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && !stop) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            rom_ce      = 1'b1;
            rom_read_en = 1'b1;
            busy        = 1'b1;
            if (stop) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_RUN: begin
            rom_ce      = 1'b1;
            rom_read_en = 1'b1;
            busy        = 1'b1;
            // Prefetch: the sample for the next period is on rom_data by the
            // time the current period ends.
            rom_address = next_addr_s;
            if (stop || finish_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // PWM compare and period pulse use registers only, never rom_data.
   assign pwm_out     = run_s && (cnt_r < duty_r);
   assign period_tick = period_end_s;
   assign done        = done_r;

   // Datapath: configuration capture, sample fetch, prescaler and PWM counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         play_addr_r <= {ADDRESS_WIDTH{1'b0}};
         duty_r      <= {DATA_WIDTH{1'b0}};
         cnt_r       <= {DATA_WIDTH{1'b0}};
         pre_r       <= {PRESCALE_WIDTH{1'b0}};
         last_addr_r <= {ADDRESS_WIDTH{1'b0}};
         loop_en_r   <= 1'b0;
         prescale_r  <= {PRESCALE_WIDTH{1'b0}};
         done_r      <= 1'b0;
      end else begin
         done_r <= finish_s && !stop;
         case (state_r)
            ST_IDLE: begin
               cnt_r <= {DATA_WIDTH{1'b0}};
               pre_r <= {PRESCALE_WIDTH{1'b0}};
               if (start && !stop) begin
                  last_addr_r <= last_addr;
                  loop_en_r   <= loop_en;
                  prescale_r  <= prescale;
               end else begin
                  last_addr_r <= last_addr_r;
               end
            end
            ST_LOAD: begin
               duty_r      <= rom_data;
               play_addr_r <= {ADDRESS_WIDTH{1'b0}};
               cnt_r       <= {DATA_WIDTH{1'b0}};
               pre_r       <= {PRESCALE_WIDTH{1'b0}};
            end
            ST_RUN: begin
               if (tick_s) begin
                  pre_r <= {PRESCALE_WIDTH{1'b0}};
                  if (cnt_r != CNT_MAX) begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end else begin
                     cnt_r <= {DATA_WIDTH{1'b0}};
                     if (!(at_last_s && !loop_en_r)) begin
                        duty_r      <= rom_data;
                        play_addr_r <= next_addr_s;
                     end else begin
                        duty_r <= duty_r;
                     end
                  end
               end else begin
                  pre_r <= pre_r + PRE_ONE;
               end
            end
            default: begin
               cnt_r <= {DATA_WIDTH{1'b0}};
               pre_r <= {PRESCALE_WIDTH{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_rom_player.sv
// Self-checking bench for pwm_rom_player. A combinational ROM model feeds the
// DUT; each started run pushes one expected record per PWM period (high time,
// period length, prefetch address at period end) and a negedge monitor pops
// and compares a record on every period_tick.
module tb_pwm_rom_player;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          stop;
   logic          loop_en;
   logic [AW-1:0] last_addr;
   logic [PW-1:0] prescale;
   logic          rom_ce;
   logic          rom_read_en;
   logic [AW-1:0] rom_address;
   logic [DW-1:0] rom_data;
   logic          pwm_out;
   logic          busy;
   logic          period_tick;
   logic          done;

   logic [DW-1:0] rom_mem [0:255];

   pwm_rom_player #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .PRESCALE_WIDTH(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .loop_en(loop_en), .last_addr(last_addr), .prescale(prescale),
      .rom_ce(rom_ce), .rom_read_en(rom_read_en), .rom_address(rom_address),
      .rom_data(rom_data), .pwm_out(pwm_out), .busy(busy),
      .period_tick(period_tick), .done(done)
   );

   assign rom_data = rom_ce ? rom_mem[rom_address] : 8'h00;

   always #5 clk = ~clk;

   typedef struct {
      int high;
      int len;
      int addr;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   len_c = 0;
   int   hi_c  = 0;
   bit   prev_busy = 1'b0;
   int   done_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Period monitor: skips the LOAD cycle (first busy cycle) and scores
   // each period at its period_tick.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (!busy) begin
         len_c = 0;
         hi_c = 0;
         prev_busy = 1'b0;
      end else if (!prev_busy) begin
         prev_busy = 1'b1;
      end else begin
         len_c++;
         if (pwm_out) hi_c++;
         if (period_tick) begin
            if (sb.size() == 0) begin
               check_val("sb_unexpected_period", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_val("period_high", hi_c, e.high);
               check_val("period_len", len_c, e.len);
               check_val("prefetch_addr", {24'd0, rom_address}, e.addr);
            end
            len_c = 0;
            hi_c = 0;
         end
      end
   end

   task automatic push_exp(input int h, input int l, input int a);
      exp_t e;
      e.high = h;
      e.len  = l;
      e.addr = a;
      sb.push_back(e);
   endtask

   task automatic pulse_start(input logic lp, input logic [AW-1:0] la, input logic [PW-1:0] ps);
      loop_en   = lp;
      last_addr = la;
      prescale  = ps;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("load_busy", {31'd0, busy}, 32'd1);
      check_val("load_ce", {31'd0, rom_ce}, 32'd1);
      check_val("load_addr", {24'd0, rom_address}, 32'd0);
   endtask

   // Counts cycles from the LOAD cycle to the done pulse.
   task automatic wait_done(input string tag, input int exp_cycles);
      int c;
      c = 0;
      while (c < exp_cycles + 50) begin
         @(negedge clk);
         c++;
         if (done) break;
      end
      check_val({tag, "_done_latency"}, c, exp_cycles);
      check_val({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check_val({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
   endtask

   task automatic wait_ticks(input int n);
      int got;
      int c;
      got = 0;
      c = 0;
      while (got < n && c < n * 1000) begin
         @(negedge clk);
         c++;
         if (period_tick) got++;
      end
      check_val("tick_count", got, n);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      loop_en = 1'b0;
      last_addr = 8'd0;
      prescale = 16'd0;
      for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_pwm", {31'd0, pwm_out}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_ce", {30'd0, rom_ce, rom_read_en}, 32'd0);
      check_val("rst_addr", {24'd0, rom_address}, 32'd0);
      check_val("rst_pulses", {30'd0, period_tick, done}, 32'd0);

      // Single pass over four samples.
      rom_mem[0] = 8'h00; rom_mem[1] = 8'hFF; rom_mem[2] = 8'h80; rom_mem[3] = 8'h01;
      push_exp(0, 255, 1);
      push_exp(255, 255, 2);
      push_exp(128, 255, 3);
      push_exp(1, 255, 0);
      pulse_start(1'b0, 8'd3, 16'd0);
      wait_done("pass", 1021);
      check_val("pass_sb_drained", sb.size(), 32'd0);

      // Prescaled single sample.
      rom_mem[0] = 8'h80;
      push_exp(384, 765, 0);
      pulse_start(1'b0, 8'd0, 16'd2);
      wait_done("prescale", 766);

      // Edge duties.
      rom_mem[0] = 8'h00;
      push_exp(0, 255, 0);
      pulse_start(1'b0, 8'd0, 16'd0);
      wait_done("duty_zero", 256);
      rom_mem[0] = 8'hFF;
      push_exp(255, 255, 0);
      pulse_start(1'b0, 8'd0, 16'd0);
      wait_done("duty_full", 256);

      // Looping run; a start pulse and config changes mid-run are ignored.
      rom_mem[0] = 8'h40; rom_mem[1] = 8'hC0;
      for (int i = 0; i < 3; i++) begin
         push_exp(64, 255, 1);
         push_exp(192, 255, 0);
      end
      done_cnt = 0;
      pulse_start(1'b1, 8'd1, 16'd0);
      wait_ticks(2);
      repeat (10) @(negedge clk);
      start = 1'b1;
      loop_en = 1'b0;
      last_addr = 8'd0;
      prescale = 16'd5;
      @(negedge clk);
      start = 1'b0;
      wait_ticks(4);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check_val("loop_stop_busy", {31'd0, busy}, 32'd0);
      check_val("loop_no_done", done_cnt, 32'd0);
      check_val("loop_sb_drained", sb.size(), 32'd0);

      // Abort at cnt = 100 of period 2.
      rom_mem[0] = 8'h80; rom_mem[1] = 8'hFF; rom_mem[2] = 8'h00;
      push_exp(128, 255, 1);
      done_cnt = 0;
      pulse_start(1'b0, 8'd2, 16'd0);
      wait_ticks(1);
      repeat (101) @(negedge clk);
      check_val("abort_pwm_before", {31'd0, pwm_out}, 32'd1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_pwm", {31'd0, pwm_out}, 32'd0);
      check_val("abort_ce", {31'd0, rom_ce}, 32'd0);
      repeat (5) @(negedge clk);
      check_val("abort_no_done", done_cnt, 32'd0);

      // Asynchronous reset in the middle of a run.
      rom_mem[0] = 8'hFF;
      push_exp(255, 255, 0);
      pulse_start(1'b0, 8'd0, 16'd0);
      repeat (50) @(negedge clk);
      check_val("pre_reset_pwm", {31'd0, pwm_out}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_pwm", {31'd0, pwm_out}, 32'd0);
      check_val("async_rst_busy", {31'd0, busy}, 32'd0);
      check_val("async_rst_ce", {30'd0, rom_ce, rom_read_en}, 32'd0);
      check_val("async_rst_addr", {24'd0, rom_address}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      rom_mem[0] = 8'h80;
      push_exp(128, 255, 0);
      pulse_start(1'b0, 8'd0, 16'd0);
      wait_done("after_reset", 256);
      check_val("final_sb_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
